// File: rtl/image_stream_reader.sv
// Byte-stream reader for the output image banks behind the data memory manager.
// Define IMG_CHECKSUM_EN to add checksum_o, a 16-bit wrapping sum of streamed bytes.
module image_stream_reader #(
    parameter int FIFO_DEPTH = 2,
    parameter int OFFSET_W   = 16
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                start_i,
    input  logic [2:0]          bank_i,
    input  logic [OFFSET_W-1:0] base_i,
    input  logic [OFFSET_W:0]   count_i,
    output logic [31:0]         address_o,
    output logic                wren_o,
    output logic [31:0]         byte_mode_o,
    input  logic [31:0]         rd_data_i,
    output logic [7:0]          tx_data_o,
    output logic                tx_valid_o,
    input  logic                tx_ready_i,
    output logic                busy_o,
    output logic                done_o
`ifdef IMG_CHECKSUM_EN
    ,
    output logic [15:0]         checksum_o
`endif
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [OFFSET_W:0] MAX_CNT = {1'b1, {OFFSET_W{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          bank_q, bank_d;
    logic [OFFSET_W-1:0] off_q, off_d;
    logic [OFFSET_W:0]   rem_q, rem_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [31:0]         addr_q;
    logic                inflight_q;
    logic [7:0]          fifo_q [FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]       occ_q;

    logic                issue;
    logic                start_acc;
    logic                pop;
    logic [31:0]         fill;
    logic [31:0]         addr_issue;
    logic [OFFSET_W:0]   cnt_clamp;
    logic                unused_rd;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign unused_rd   = ^rd_data_i[31:8];
    assign wren_o      = 1'b0;
    assign byte_mode_o = 32'd1;
    assign tx_valid_o  = (occ_q != '0);
    assign tx_data_o   = fifo_q[rd_ptr_q];
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign pop         = tx_valid_o & tx_ready_i;
    assign addr_issue  = 32'({bank_q, off_q});
    assign address_o   = issue ? addr_issue : addr_q;
    assign cnt_clamp   = (count_i > MAX_CNT) ? MAX_CNT : count_i;

    // Slots already claimed: buffered bytes plus the one returning this cycle.
    assign fill = 32'(occ_q) + 32'(inflight_q) - 32'(pop);

    always_comb begin
        state_d   = state_q;
        bank_d    = bank_q;
        off_d     = off_q;
        rem_d     = rem_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        issue     = 1'b0;
        start_acc = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    start_acc = 1'b1;
                    bank_d    = bank_i;
                    off_d     = base_i;
                    rem_d     = cnt_clamp;
                    if (cnt_clamp == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_READ;
                        busy_d  = 1'b1;
                    end
                end
            end
            S_READ: begin
                if (rem_q != '0 && fill < 32'(FIFO_DEPTH)) begin
                    issue = 1'b1;
                    off_d = off_q + 1'b1;
                    rem_d = rem_q - 1'b1;
                    if (rem_q == 1) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (32'(occ_q) == 32'(pop) && !inflight_q) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            bank_q     <= '0;
            off_q      <= '0;
            rem_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            addr_q     <= '0;
            inflight_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            bank_q     <= bank_d;
            off_q      <= off_d;
            rem_q      <= rem_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            inflight_q <= issue;
            if (issue) addr_q <= addr_issue;
            if (inflight_q) begin
                fifo_q[wr_ptr_q] <= rd_data_i[7:0];
                wr_ptr_q         <= nxt(wr_ptr_q);
            end
            if (pop) rd_ptr_q <= nxt(rd_ptr_q);
            occ_q <= occ_q + CW'(inflight_q) - CW'(pop);
        end
    end

`ifdef IMG_CHECKSUM_EN
    logic [15:0] sum_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sum_q <= '0;
        end else if (start_acc) begin
            sum_q <= '0;
        end else if (pop) begin
            sum_q <= sum_q + {8'h00, tx_data_o};
        end
    end

    assign checksum_o = sum_q;
`endif

endmodule

// File: tb/tb_image_stream_reader.sv
// Bench for image_stream_reader: registered memory model, byte scoreboard.
module tb_image_stream_reader;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        start_i = 1'b0;
    logic [2:0]  bank_i = '0;
    logic [15:0] base_i = '0;
    logic [16:0] count_i = '0;
    logic [31:0] address_o;
    logic        wren_o;
    logic [31:0] byte_mode_o;
    logic [31:0] rd_data_i = '0;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i = 1'b1;
    logic        busy_o;
    logic        done_o;
`ifdef IMG_CHECKSUM_EN
    logic [15:0] checksum_o;
`endif

    logic [7:0]  mem [0:524287];
    logic [7:0]  exp_q [$];
    int          total = 0;
    int          bad = 0;
    int          xfers = 0;
    logic [15:0] sum_m = '0;

    image_stream_reader dut (
        .CLK         (CLK),
        .RST         (RST),
        .start_i     (start_i),
        .bank_i      (bank_i),
        .base_i      (base_i),
        .count_i     (count_i),
        .address_o   (address_o),
        .wren_o      (wren_o),
        .byte_mode_o (byte_mode_o),
        .rd_data_i   (rd_data_i),
        .tx_data_o   (tx_data_o),
        .tx_valid_o  (tx_valid_o),
        .tx_ready_i  (tx_ready_i),
        .busy_o      (busy_o),
        .done_o      (done_o)
`ifdef IMG_CHECKSUM_EN
        ,
        .checksum_o  (checksum_o)
`endif
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) rd_data_i <= {24'h0, mem[address_o[18:0]]};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (!RST && tx_valid_o) begin
            if (exp_q.size() == 0) begin
                chk("sb_empty", 32'(exp_q.size()), 32'd1);
            end else begin
                chk("txbyte", 32'(tx_data_o), 32'(exp_q[0]));
                if (tx_ready_i) begin
                    sum_m = sum_m + 16'(exp_q[0]);
                    void'(exp_q.pop_front());
                    xfers++;
                end
            end
        end
    end

    task automatic xfer(input logic [2:0] b, input logic [15:0] base,
                        input logic [16:0] cnt, input bit bp,
                        input bit chk_addr, input bit poke, input int exp_done);
        int          n;
        int          x0;
        int          done_at;
        logic [7:0]  pat;
        logic [15:0] off;
        n = (cnt > 17'd65536) ? 65536 : int'(cnt);
        for (int i = 0; i < n; i++) begin
            off = base + 16'(i);
            exp_q.push_back(mem[{b, off}]);
        end
        pat     = 8'b0110_1001;
        sum_m   = '0;
        x0      = xfers;
        done_at = -1;
        for (int c = 0; c < 3000 && done_at < 0; c++) begin
            @(posedge CLK);
            #1;
            start_i = (c == 0) || (poke && c == 5);
            if (c == 0) begin
                bank_i  = b;
                base_i  = base;
                count_i = cnt;
            end else if (poke && c == 5) begin
                bank_i  = 3'd6;
                base_i  = 16'h0100;
                count_i = 17'd3;
            end
            tx_ready_i = bp ? pat[c % 8] : 1'b1;
            @(negedge CLK);
            if (chk_addr && c >= 1 && c <= 4) begin
                off = base + 16'(c - 1);
                chk("addr", address_o, {13'h0, b, off});
                chk("valid_lat", 32'(tx_valid_o), 32'(c >= 3));
            end
            if (c == 1 && n != 0) chk("busy", 32'(busy_o), 32'd1);
            if (done_o) done_at = c;
        end
        start_i    = 1'b0;
        tx_ready_i = 1'b1;
        chk("done_seen", 32'(done_at >= 0), 32'd1);
        if (exp_done > 0) chk("done_cyc", 32'(done_at), 32'(exp_done));
        chk("busy_end", 32'(busy_o), 32'd0);
        chk("nbytes", 32'(xfers - x0), 32'(n));
        chk("sb_left", 32'(exp_q.size()), 32'd0);
`ifdef IMG_CHECKSUM_EN
        chk("cksum", 32'(checksum_o), 32'(sum_m));
`endif
    endtask

    task automatic rst_mid();
        int          x0;
        int          k;
        logic [15:0] off;
        for (int i = 0; i < 8; i++) begin
            off = 16'h0020 + 16'(i);
            exp_q.push_back(mem[{3'd6, off}]);
        end
        x0 = xfers;
        @(posedge CLK);
        #1;
        start_i    = 1'b1;
        bank_i     = 3'd6;
        base_i     = 16'h0020;
        count_i    = 17'd8;
        tx_ready_i = 1'b1;
        @(posedge CLK);
        #1;
        start_i = 1'b0;
        k = 0;
        while (xfers - x0 < 3 && k < 50) begin
            @(negedge CLK);
            k++;
        end
        chk("rst_reach3", 32'(xfers - x0 >= 3), 32'd1);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        exp_q.delete();
        @(posedge CLK);
        @(negedge CLK);
        chk("rst_valid", 32'(tx_valid_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            chk("rst_nodone", 32'(done_o), 32'd0);
        end
    endtask

    initial begin
        for (int a = 0; a < 524288; a++) mem[a] = 8'(a ^ (a >> 8) ^ (a >> 16));
        for (int i = 0; i < 4; i++) mem[32'h40000 + i] = 8'(8'h10 + i);

        RST = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_addr", address_o, 32'd0);
        chk("rst_txdata", 32'(tx_data_o), 32'd0);
        chk("rst_txvalid", 32'(tx_valid_o), 32'd0);
        chk("rst_busy0", 32'(busy_o), 32'd0);
        chk("rst_done0", 32'(done_o), 32'd0);
        chk("wren", 32'(wren_o), 32'd0);
        chk("bytemode", byte_mode_o, 32'd1);
`ifdef IMG_CHECKSUM_EN
        chk("rst_cksum", 32'(checksum_o), 32'd0);
`endif
        @(posedge CLK);
        #1;
        RST = 1'b0;

        xfer(3'd4, 16'h0000, 17'd4, 1'b0, 1'b1, 1'b0, 7);
`ifdef IMG_CHECKSUM_EN
        chk("cksum_basic", 32'(checksum_o), 32'h0046);
`endif
        xfer(3'd4, 16'h0010, 17'd8, 1'b1, 1'b0, 1'b1, 0);
        xfer(3'd5, 16'hFFFE, 17'd4, 1'b0, 1'b1, 1'b0, 7);
        xfer(3'd5, 16'h1234, 17'd0, 1'b0, 1'b0, 1'b0, 1);
        chk("addr_hold", address_o, 32'h0005_0001);
        rst_mid();
        xfer(3'd6, 16'h0040, 17'd2, 1'b0, 1'b0, 1'b0, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
